// File: rtl/cdb_arbiter_pkg.sv
// Shared widths and helpers for the CDB arbiter slice.
package cdb_arbiter_pkg;

    localparam int unsigned ROB_IDX_W = 5;
    localparam int unsigned DATA_W    = 32;

    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1) % n;
    endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// FU result handshake and CDB broadcast bundle; master is the FU side, slave the arbiter.
interface cdb_arbiter_if
    import cdb_arbiter_pkg::*;
#(
    parameter int unsigned NUM_FU = 4,
    parameter int unsigned TAG_W  = ROB_IDX_W
) ();

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] value;
        logic              take_branch;
    } cdb_packet_t;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] value;
        logic              take_branch;
    } fu_result_packet_t;

    logic [NUM_FU-1:0]             fu_valid;
    logic [NUM_FU-1:0][TAG_W-1:0]  fu_tag;
    logic [NUM_FU-1:0][DATA_W-1:0] fu_value;
    logic [NUM_FU-1:0]             fu_take_branch;
    logic [NUM_FU-1:0]             fu_ready;
    cdb_packet_t                   cdb_packet_out;

    modport master (
        output fu_valid, fu_tag, fu_value, fu_take_branch,
        input  fu_ready, cdb_packet_out
    );

    modport slave (
        input  fu_valid, fu_tag, fu_value, fu_take_branch,
        output fu_ready, cdb_packet_out
    );

endinterface

// File: rtl/cdb_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr, wrapping modulo NUM_FU.
module rr_arbiter #(
    parameter int unsigned NUM_FU = 4,
    parameter int unsigned PTR_W  = $clog2(NUM_FU)
) (
    input  logic [NUM_FU-1:0] req,
    input  logic [PTR_W-1:0]  ptr,
    output logic [NUM_FU-1:0] grant,
    output logic              grant_valid
);

    always_comb begin
        int unsigned      idx;
        logic [PTR_W-1:0] sel;
        idx         = 0;
        sel         = '0;
        grant       = '0;
        grant_valid = 1'b0;
        for (int unsigned off = 0; off < NUM_FU; off++) begin
            idx = (32'(ptr) + off) % NUM_FU;
            sel = PTR_W'(idx);
            if (!grant_valid && req[sel]) begin
                grant[sel]  = 1'b1;
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one holding buffer per FU, round-robin broadcast of one result per cycle.
// Define CDB_BYPASS_EN to let a transfer into an empty buffer compete for the CDB in the same cycle.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int unsigned NUM_FU = 4,
    parameter int unsigned TAG_W  = ROB_IDX_W
) (
    input logic          clock,
    input logic          reset,
    input logic          squash,
    cdb_arbiter_if.slave bus
);

    localparam int unsigned PTR_W = $clog2(NUM_FU);

    logic [NUM_FU-1:0] buf_valid;
    logic [TAG_W-1:0]  buf_tag   [NUM_FU];
    logic [DATA_W-1:0] buf_value [NUM_FU];
    logic [NUM_FU-1:0] buf_take_branch;
    logic [PTR_W-1:0]  rr_ptr;
    logic [PTR_W-1:0]  next_ptr;
    logic [NUM_FU-1:0] req;
    logic [NUM_FU-1:0] grant;
    logic              grant_valid;
    logic [NUM_FU-1:0] xfer;
    logic [NUM_FU-1:0] load;

    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_value;
    logic              cdb_take_branch;
    logic [TAG_W-1:0]  sel_tag;
    logic [DATA_W-1:0] sel_value;
    logic              sel_take_branch;

`ifdef CDB_BYPASS_EN
    assign req = buf_valid | bus.fu_valid;
`else
    assign req = buf_valid;
`endif

    rr_arbiter #(
        .NUM_FU (NUM_FU),
        .PTR_W  (PTR_W)
    ) u_rr_arbiter (
        .req         (req),
        .ptr         (rr_ptr),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    assign bus.fu_ready = ~buf_valid | grant;
    assign xfer         = bus.fu_valid & bus.fu_ready;
    // A grant on an empty buffer can only be a bypassed transfer: broadcast it, do not store it
    assign load         = xfer & ~(grant & ~buf_valid);

    always_comb begin
        sel_tag         = '0;
        sel_value       = '0;
        sel_take_branch = 1'b0;
        next_ptr        = rr_ptr;
        for (int unsigned i = 0; i < NUM_FU; i++) begin
            if (grant[i]) begin
                next_ptr = PTR_W'(rr_next(i, NUM_FU));
`ifdef CDB_BYPASS_EN
                if (!buf_valid[i]) begin
                    sel_tag         = bus.fu_tag[i];
                    sel_value       = bus.fu_value[i];
                    sel_take_branch = bus.fu_take_branch[i];
                end else begin
                    sel_tag         = buf_tag[i];
                    sel_value       = buf_value[i];
                    sel_take_branch = buf_take_branch[i];
                end
`else
                sel_tag         = buf_tag[i];
                sel_value       = buf_value[i];
                sel_take_branch = buf_take_branch[i];
`endif
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            buf_valid       <= '0;
            buf_take_branch <= '0;
            rr_ptr          <= '0;
            cdb_valid       <= 1'b0;
            cdb_tag         <= '0;
            cdb_value       <= '0;
            cdb_take_branch <= 1'b0;
            for (int unsigned i = 0; i < NUM_FU; i++) begin
                buf_tag[i]   <= '0;
                buf_value[i] <= '0;
            end
        end else if (squash) begin
            buf_valid <= '0;
            cdb_valid <= 1'b0;
        end else begin
            cdb_valid <= grant_valid;
            if (grant_valid) begin
                cdb_tag         <= sel_tag;
                cdb_value       <= sel_value;
                cdb_take_branch <= sel_take_branch;
                rr_ptr          <= next_ptr;
            end
            for (int unsigned i = 0; i < NUM_FU; i++) begin
                if (load[i]) begin
                    buf_valid[i]       <= 1'b1;
                    buf_tag[i]         <= bus.fu_tag[i];
                    buf_value[i]       <= bus.fu_value[i];
                    buf_take_branch[i] <= bus.fu_take_branch[i];
                end else if (grant[i]) begin
                    buf_valid[i] <= 1'b0;
                end
            end
        end
    end

    assign bus.cdb_packet_out = {cdb_valid, cdb_tag, cdb_value, cdb_take_branch};

endmodule
